// File: rtl/rtc_pkg.sv
// Shared types, field limits and wrap helpers for the RTC timekeeper.
package rtc_pkg;

    typedef enum logic [1:0] {
        FLD_SEC  = 2'd0,
        FLD_MIN  = 2'd1,
        FLD_HR   = 2'd2,
        FLD_NONE = 2'd3
    } field_e;

    localparam logic [7:0] SEC_MAX = 8'd59;
    localparam logic [7:0] MIN_MAX = 8'd59;
    localparam logic [7:0] HR_MAX  = 8'd23;

    function automatic logic [7:0] wrap_inc(
        input logic [7:0] v,
        input logic [7:0] max
    );
        return (v >= max) ? 8'd0 : v + 8'd1;
    endfunction

    function automatic logic [7:0] wrap_dec(
        input logic [7:0] v,
        input logic [7:0] max
    );
        return (v == 8'd0) ? max : v - 8'd1;
    endfunction

endpackage

// File: rtl/rtc_timekeeper_btn.sv
// Button synchroniser chain followed by a rising-edge detector.
import rtc_pkg::*;

module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_btn,
    output logic o_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/rtc_timekeeper.sv
// Real-time clock core: prescaled seconds/minutes/hours with button set,
// hold, 12/24h display and one-shot alarm.
import rtc_pkg::*;

module rtc_timekeeper #(
    parameter int CLOCK_FREQ  = 50000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       INC,
    input  logic       DEC,
    input  logic [1:0] FIELD,
    input  logic       HOLD,
    input  logic       MODE_12H,
    input  logic       ALARM_EN,
    input  logic [4:0] ALARM_HH,
    input  logic [5:0] ALARM_MM,
    output logic [7:0] seconds,
    output logic [7:0] minutes,
    output logic [7:0] hours,
    output logic       pm,
    output logic       sec_tick,
    output logic       alarm_hit
);

    localparam int PRESC_W = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(CLOCK_FREQ - 1);

    logic [PRESC_W-1:0] r_presc;
    logic [7:0]         r_sec, r_min, r_hr;
    logic               r_tick_d, r_alarm_d;

    logic               w_inc_p, w_dec_p;
    logic               w_edit, w_term, w_tick, w_alarm;
    logic [7:0]         w_sec_n, w_min_n, w_hr_n, w_disp_hr;
    logic [PRESC_W-1:0] w_presc_n;

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_inc (
        .CLK     (CLK),
        .RST     (RST),
        .i_btn   (INC),
        .o_pulse (w_inc_p)
    );

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_dec (
        .CLK     (CLK),
        .RST     (RST),
        .i_btn   (DEC),
        .o_pulse (w_dec_p)
    );

    assign w_edit = (w_inc_p ^ w_dec_p) && (field_e'(FIELD) != FLD_NONE);
    assign w_term = !HOLD && (r_presc == PRESC_TC);
    // A manual edit in the terminal cycle swallows the tick entirely.
    assign w_tick = w_term && !w_edit;

    always_comb begin
        w_sec_n = r_sec;
        w_min_n = r_min;
        w_hr_n  = r_hr;
        if (w_edit) begin
            case (field_e'(FIELD))
                FLD_SEC: w_sec_n = w_inc_p ? wrap_inc(r_sec, SEC_MAX)
                                           : wrap_dec(r_sec, SEC_MAX);
                FLD_MIN: w_min_n = w_inc_p ? wrap_inc(r_min, MIN_MAX)
                                           : wrap_dec(r_min, MIN_MAX);
                FLD_HR:  w_hr_n  = w_inc_p ? wrap_inc(r_hr, HR_MAX)
                                           : wrap_dec(r_hr, HR_MAX);
                default: ;
            endcase
        end else if (w_tick) begin
            w_sec_n = wrap_inc(r_sec, SEC_MAX);
            if (r_sec == SEC_MAX) begin
                w_min_n = wrap_inc(r_min, MIN_MAX);
                if (r_min == MIN_MAX)
                    w_hr_n = wrap_inc(r_hr, HR_MAX);
            end
        end
    end

    always_comb begin
        w_presc_n = r_presc + 1'b1;
        if (HOLD || w_term || (w_edit && field_e'(FIELD) == FLD_SEC))
            w_presc_n = '0;
    end

    assign w_alarm = w_tick && ALARM_EN && (w_sec_n == 8'd0)
                  && (w_min_n == {2'b00, ALARM_MM})
                  && (w_hr_n == {3'b000, ALARM_HH});

    always_comb begin
        w_disp_hr = r_hr;
        if (MODE_12H) begin
            if (r_hr == 8'd0)
                w_disp_hr = 8'd12;
            else if (r_hr > 8'd12)
                w_disp_hr = r_hr - 8'd12;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_presc   <= '0;
            r_sec     <= 8'd0;
            r_min     <= 8'd0;
            r_hr      <= 8'd0;
            r_tick_d  <= 1'b0;
            r_alarm_d <= 1'b0;
        end else begin
            r_presc   <= w_presc_n;
            r_sec     <= w_sec_n;
            r_min     <= w_min_n;
            r_hr      <= w_hr_n;
            r_tick_d  <= w_tick;
            r_alarm_d <= w_alarm;
        end
    end

    // Output stage: pulses are delayed to line up with the displayed value.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            seconds   <= 8'd0;
            minutes   <= 8'd0;
            hours     <= 8'd0;
            pm        <= 1'b0;
            sec_tick  <= 1'b0;
            alarm_hit <= 1'b0;
        end else begin
            seconds   <= r_sec;
            minutes   <= r_min;
            hours     <= w_disp_hr;
            pm        <= (r_hr >= 8'd12);
            sec_tick  <= r_tick_d;
            alarm_hit <= r_alarm_d;
        end
    end

endmodule
